sw_stream_ctrl: RTL and testbench
=================================

SW_STREAM_CTRL -- requirements
Module: sw_stream_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of engine run cycles before the watchdog aborts.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the query counter and the query index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port si_valid, input, 1 bit: an input stream word is present.
REQ-006 SHALL have port si_rdy, output, 1 bit: the block accepts the input word.
REQ-007 SHALL have port si_data, input, 128 bits: the input stream word (header or query).
REQ-008 SHALL have port so_valid, output, 1 bit: a result word is present.
REQ-009 SHALL have port so_rdy, input, 1 bit: the consumer accepts the result word.
REQ-010 SHALL have port so_data, output, 128 bits: the result word.
REQ-011 SHALL have ports ref_req_valid (output, 1 bit), ref_req_rdy (input, 1 bit), ref_req_addr (output, 32 bits), ref_req_len (output, 32 bits): the DRAM reference-fetch request.
REQ-012 SHALL have ports eng_query (output, 128 bits), eng_start (output, 1 bit, pulse), eng_done (input, 1 bit, pulse), eng_score (input, 16 bits), eng_loc (input, 32 bits): the Smith-Waterman engine.

Function
REQ-013 SHALL transfer a word on any interface only in a cycle where valid and rdy are both high.
REQ-014 SHALL decode the header word as: [127:96] reference length in bases, [95:64] query count, [63:32] reference start byte address, [31:0] score threshold (low 16 bits used).
REQ-015 SHALL implement the FSM IDLE -> LOAD_Q -> REQ_REF -> RUN -> EMIT -> (LOAD_Q if queries remain, else IDLE).
REQ-016 SHALL hold si_rdy high only in IDLE and LOAD_Q, and low in all other states.
REQ-017 In IDLE, on a header transfer, SHALL latch the header fields, clear the query index to 0, and go to LOAD_Q; a query count of 0 SHALL return to IDLE with no output.
REQ-018 In LOAD_Q, on a word transfer, SHALL latch it into eng_query and go to REQ_REF.
REQ-019 In REQ_REF, SHALL assert ref_req_valid with ref_req_addr = start address and ref_req_len = reference length.
REQ-020 On the ref_req transfer, SHALL pulse eng_start for exactly 1 cycle and enter RUN.
REQ-021 If the reference length is 0, REQ_REF SHALL skip the fetch and the engine and go directly to EMIT with score 0 and location 0xFFFFFFFF.
REQ-022 In RUN, SHALL count cycles from 0, and on eng_done SHALL latch eng_score and eng_loc and go to EMIT.
REQ-023 If the count reaches TIMEOUT_CYCLES without eng_done, SHALL go to EMIT with the error flag set.
REQ-024 An eng_done arriving in the same cycle as the timeout SHALL take priority over the timeout.
REQ-025 In EMIT, SHALL drive so_data = {error flag at [127], zeros [126:64], score [63:48], query index [47:32], location [31:0]} and hold it stable until the transfer.
REQ-026 In EMIT, location SHALL be eng_loc when score >= threshold, else 0xFFFFFFFF; on timeout, score = 0 and location = 0xFFFFFFFF.
REQ-027 After the EMIT transfer, SHALL increment the query index, wrapping modulo 2^CNT_W, and go to LOAD_Q if index+1 < query count, else to IDLE.
REQ-028 SHALL ignore eng_done in every state other than RUN.
REQ-029 Latency from the query-word transfer to ref_req_valid SHALL be 1 cycle, and from eng_done to so_valid SHALL be 1 cycle.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE and drive si_rdy, so_valid, ref_req_valid and eng_start to 0, and so_data, eng_query, ref_req_addr, ref_req_len and all counters to 0.
REQ-031 Reset asserted mid-operation SHALL abandon the query without output; the first transfer after reset SHALL be decoded as a header.

Structure
REQ-032 The FSM state encoding, header field bit positions, result field positions and the NO_HIT constant 0xFFFFFFFF SHALL reside in the shared package sw_pkg.
REQ-033 The watchdog counter SHALL be a sub-module, sw_watchdog (inputs clear and enable; output expired).

Verification
REQ-034 Header 0x00000080_00000001_00000000_000000FF, then query 0xc8facaa7c280aa28a020aaaf89aae004; engine returns score 0x0100 and loc 0x40 -> so_data[63:0] = 0x0100_0000_00000040, followed by a return to IDLE.
REQ-035 Same header with a returned score of 0x0010 (below threshold) -> location 0xFFFFFFFF, score 0x0010.
REQ-036 Query count 3 with so_rdy held low for 5 cycles on each result -> 3 results with indices 0, 1, 2, so_data stable while stalled, and si_rdy low during EMIT.
REQ-037 Engine never asserts done, with TIMEOUT_CYCLES = 16 -> result arrives 17 cycles after eng_start with bit 127 = 1 and location 0xFFFFFFFF.
REQ-038 Reference length 0 -> no ref_req, no eng_start, result score 0 and location 0xFFFFFFFF; query count 0 -> no output.
REQ-039 rst_n pulsed low during RUN -> all outputs 0 immediately; the next header and query are processed normally.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman stream controller: FSM encoding,
// header/result word layouts and the no-hit location marker.
package sw_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_Q  = 3'd1,
        S_REQ_REF = 3'd2,
        S_RUN     = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    // Field order of the packed structs fixes the bit positions in the 128-bit words.
    typedef struct packed {
        logic [31:0] ref_len;
        logic [31:0] q_count;
        logic [31:0] ref_addr;
        logic [31:0] threshold;
    } header_t;

    typedef struct packed {
        logic        err;
        logic [62:0] zero;
        logic [15:0] score;
        logic [15:0] idx;
        logic [31:0] loc;
    } result_t;

    localparam logic [31:0] NO_HIT = 32'hFFFF_FFFF;

    function automatic logic [127:0] pack_result(input logic        err,
                                                 input logic [15:0] score,
                                                 input logic [15:0] idx,
                                                 input logic [31:0] loc);
        result_t r;
        r.err   = err;
        r.zero  = '0;
        r.score = score;
        r.idx   = idx;
        r.loc   = loc;
        return r;
    endfunction

endpackage

// File: rtl/sw_watchdog.sv
// Run-cycle counter for the engine; expired rises once the count reaches
// TIMEOUT_CYCLES and holds there until cleared.
module sw_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT_CYCLES));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sw_stream_ctrl.sv
// Sequences header/query words from the input stream through a reference fetch
// and one Smith-Waterman engine run per query, emitting one result word each.
module sw_stream_ctrl
    import sw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         si_valid,
    output logic         si_rdy,
    input  logic [127:0] si_data,
    output logic         so_valid,
    input  logic         so_rdy,
    output logic [127:0] so_data,
    output logic         ref_req_valid,
    input  logic         ref_req_rdy,
    output logic [31:0]  ref_req_addr,
    output logic [31:0]  ref_req_len,
    output logic [127:0] eng_query,
    output logic         eng_start,
    input  logic         eng_done,
    input  logic [15:0]  eng_score,
    input  logic [31:0]  eng_loc
);
    state_t           state;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] q_idx;
    logic [CNT_W-1:0] next_idx;
    logic [15:0]      threshold;
    logic [15:0]      idx16;
    logic             wd_expired;
    header_t          hdr;
    logic             unused_hdr_bits;

    assign hdr             = header_t'(si_data);
    assign next_idx        = q_idx + CNT_W'(1);
    assign idx16           = 16'(q_idx);
    assign unused_hdr_bits = ^{hdr.threshold[31:16], hdr.q_count};

    // The counter only runs in RUN and is held at zero everywhere else, so it
    // starts from 0 on the first RUN cycle.
    sw_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != S_RUN),
        .enable (state == S_RUN),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            si_rdy        <= 1'b0;
            so_valid      <= 1'b0;
            so_data       <= '0;
            ref_req_valid <= 1'b0;
            ref_req_addr  <= '0;
            ref_req_len   <= '0;
            eng_query     <= '0;
            eng_start     <= 1'b0;
            q_count       <= '0;
            q_idx         <= '0;
            threshold     <= '0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    si_rdy <= 1'b1;
                    if (si_valid && si_rdy) begin
                        ref_req_len  <= hdr.ref_len;
                        ref_req_addr <= hdr.ref_addr;
                        q_count      <= CNT_W'(hdr.q_count);
                        threshold    <= hdr.threshold[15:0];
                        q_idx        <= '0;
                        if (CNT_W'(hdr.q_count) != '0) begin
                            state <= S_LOAD_Q;
                        end
                    end
                end

                S_LOAD_Q: begin
                    if (si_valid && si_rdy) begin
                        eng_query     <= si_data;
                        si_rdy        <= 1'b0;
                        ref_req_valid <= (ref_req_len != '0);
                        state         <= S_REQ_REF;
                    end
                end

                S_REQ_REF: begin
                    if (ref_req_len == '0) begin
                        so_data  <= pack_result(1'b0, 16'd0, idx16, NO_HIT);
                        so_valid <= 1'b1;
                        state    <= S_EMIT;
                    end else if (ref_req_valid && ref_req_rdy) begin
                        ref_req_valid <= 1'b0;
                        eng_start     <= 1'b1;
                        state         <= S_RUN;
                    end
                end

                S_RUN: begin
                    // A done arriving on the timeout cycle still reports the real score.
                    if (eng_done) begin
                        so_data  <= pack_result(1'b0, eng_score, idx16,
                                                (eng_score >= threshold) ? eng_loc : NO_HIT);
                        so_valid <= 1'b1;
                        state    <= S_EMIT;
                    end else if (wd_expired) begin
                        so_data  <= pack_result(1'b1, 16'd0, idx16, NO_HIT);
                        so_valid <= 1'b1;
                        state    <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (so_valid && so_rdy) begin
                        so_valid <= 1'b0;
                        q_idx    <= next_idx;
                        si_rdy   <= 1'b1;
                        state    <= (next_idx < q_count) ? S_LOAD_Q : S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_stream_ctrl.sv
// Randomized self-checking bench for sw_stream_ctrl; expected result words come
// from a behavioural model of the scoring rules.
module tb_sw_stream_ctrl;
    localparam int TO = 16;
    localparam logic [31:0] NOHIT = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         si_valid = 1'b0;
    logic         si_rdy;
    logic [127:0] si_data = '0;
    logic         so_valid;
    logic         so_rdy = 1'b0;
    logic [127:0] so_data;
    logic         ref_req_valid;
    logic         ref_req_rdy = 1'b0;
    logic [31:0]  ref_req_addr;
    logic [31:0]  ref_req_len;
    logic [127:0] eng_query;
    logic         eng_start;
    logic         eng_done = 1'b0;
    logic [15:0]  eng_score = '0;
    logic [31:0]  eng_loc = '0;

    int n_pass = 0;
    int n_total = 0;

    sw_stream_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .si_valid     (si_valid),
        .si_rdy       (si_rdy),
        .si_data      (si_data),
        .so_valid     (so_valid),
        .so_rdy       (so_rdy),
        .so_data      (so_data),
        .ref_req_valid(ref_req_valid),
        .ref_req_rdy  (ref_req_rdy),
        .ref_req_addr (ref_req_addr),
        .ref_req_len  (ref_req_len),
        .eng_query    (eng_query),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .eng_score    (eng_score),
        .eng_loc      (eng_loc)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected result word for one query, straight from the scoring rules.
    function automatic logic [127:0] model_result(input logic [31:0] len, input bit timed_out,
                                                  input logic [15:0] score, input logic [31:0] loc,
                                                  input logic [15:0] thr, input int idx);
        logic        e;
        logic [15:0] s;
        logic [31:0] l;
        e = 1'b0;
        s = score;
        l = loc;
        if (len == 0) begin
            s = 16'd0;
            l = NOHIT;
        end else if (timed_out) begin
            e = 1'b1;
            s = 16'd0;
            l = NOHIT;
        end else if (score < thr) begin
            l = NOHIT;
        end
        return {e, 63'd0, s, idx[15:0], l};
    endfunction

    task automatic send_word(input logic [127:0] w, input string tag);
        int cyc;
        cyc = 0;
        si_data  = w;
        si_valid = 1'b1;
        while (!si_rdy && cyc < 50) begin
            tick;
            cyc++;
        end
        n_total++;
        if (cyc >= 50) $display("FAIL %s_si_rdy: waited %0d cycles for si_rdy, need < 50", tag, cyc);
        else n_pass++;
        tick;
        si_valid = 1'b0;
        si_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // mode 0: done after 1..TO run cycles, 1: done exactly on the timeout cycle, 2: never done
    task automatic run_job(input logic [31:0] len, input logic [31:0] cnt, input logic [31:0] addr,
                           input logic [15:0] thr, input int mode, input int stall,
                           input bit fixed, input logic [127:0] fq, input logic [15:0] fs,
                           input logic [31:0] fl, input string tag);
        logic [127:0] q, exp;
        logic [15:0]  s;
        logic [31:0]  l;
        int           k, d, w;
        bit           bad, tmo;
        send_word({len, cnt, addr, 16'($urandom()), thr}, {tag, "_hdr"});
        for (int i = 0; i < int'(cnt); i++) begin
            q = fixed ? fq : {$urandom(), $urandom(), $urandom(), $urandom()};
            s = fixed ? fs : 16'($urandom());
            l = fixed ? fl : $urandom();
            tmo = 1'b0;
            send_word(q, {tag, "_query"});
            n_total++;
            if (eng_query !== q || ref_req_valid !== (len != 0))
                $display("FAIL %s_load q%0d: eng_query=%h ref_req_valid=%b, need %h / %b",
                         tag, i, eng_query, ref_req_valid, q, (len != 0));
            else n_pass++;
            if (len != 0) begin
                n_total++;
                if (ref_req_addr !== addr || ref_req_len !== len)
                    $display("FAIL %s_refreq q%0d: addr=%h len=%h, need %h / %h",
                             tag, i, ref_req_addr, ref_req_len, addr, len);
                else n_pass++;
                w = $urandom_range(0, 3);
                repeat (w) tick;
                n_total++;
                if (ref_req_valid !== 1'b1 || eng_start !== 1'b0)
                    $display("FAIL %s_refwait q%0d: ref_req_valid=%b eng_start=%b, need 1 / 0",
                             tag, i, ref_req_valid, eng_start);
                else n_pass++;
                ref_req_rdy = 1'b1;
                tick;
                ref_req_rdy = 1'b0;
                n_total++;
                if (eng_start !== 1'b1 || ref_req_valid !== 1'b0)
                    $display("FAIL %s_start q%0d: eng_start=%b ref_req_valid=%b, need 1 / 0",
                             tag, i, eng_start, ref_req_valid);
                else n_pass++;
                if (mode == 2) begin
                    tmo = 1'b1;
                    k = 0;
                    while (!so_valid && k < 40) begin
                        tick;
                        k++;
                    end
                    n_total++;
                    if (k != TO + 1)
                        $display("FAIL %s_timeout q%0d: result after %0d cycles, need %0d",
                                 tag, i, k, TO + 1);
                    else n_pass++;
                end else begin
                    d = (mode == 1) ? TO : $urandom_range(1, TO);
                    tick;
                    n_total++;
                    if (eng_start !== 1'b0)
                        $display("FAIL %s_start_pulse q%0d: eng_start=%b, need 0", tag, i, eng_start);
                    else n_pass++;
                    repeat (d - 1) tick;
                    eng_done  = 1'b1;
                    eng_score = s;
                    eng_loc   = l;
                    tick;
                    eng_done  = 1'b0;
                    eng_score = 16'($urandom());
                    eng_loc   = $urandom();
                    n_total++;
                    if (so_valid !== 1'b1)
                        $display("FAIL %s_done_latency q%0d: so_valid=%b one cycle after done, need 1",
                                 tag, i, so_valid);
                    else n_pass++;
                end
            end else begin
                k = 0;
                bad = 1'b0;
                while (!so_valid && k < 10) begin
                    tick;
                    k++;
                    if (ref_req_valid || eng_start) bad = 1'b1;
                end
                n_total++;
                if (k != 1 || bad)
                    $display("FAIL %s_zero_len q%0d: result after %0d cycles, fetch/start seen=%b, need 1 / 0",
                             tag, i, k, bad);
                else n_pass++;
            end
            exp = model_result(len, tmo, s, l, thr, i);
            for (int st = 0; st < stall; st++) begin
                n_total++;
                if (so_valid !== 1'b1 || so_data !== exp || si_rdy !== 1'b0)
                    $display("FAIL %s_stall q%0d c%0d: valid=%b rdy=%b data=%h, need 1 / 0 / %h",
                             tag, i, st, so_valid, si_rdy, so_data, exp);
                else n_pass++;
                eng_done = 1'($urandom_range(0, 1));
                tick;
            end
            eng_done = 1'b0;
            n_total++;
            if (so_valid !== 1'b1 || so_data !== exp)
                $display("FAIL %s_result q%0d: valid=%b data=%h, need 1 / %h", tag, i, so_valid, so_data, exp);
            else n_pass++;
            so_rdy = 1'b1;
            tick;
            so_rdy = 1'b0;
            n_total++;
            if (so_valid !== 1'b0 || si_rdy !== 1'b1)
                $display("FAIL %s_after_emit q%0d: so_valid=%b si_rdy=%b, need 0 / 1", tag, i, so_valid, si_rdy);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({si_rdy, so_valid, ref_req_valid, eng_start, so_data, eng_query, ref_req_addr, ref_req_len} !== '0)
            $display("FAIL reset_values: so_data=%h eng_query=%h flags=%b, need all 0",
                     so_data, eng_query, {si_rdy, so_valid, ref_req_valid, eng_start});
        else n_pass++;
        repeat (3) tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
        n_total++;
        if (si_rdy !== 1'b1 || so_valid !== 1'b0)
            $display("FAIL reset_release: si_rdy=%b so_valid=%b, need 1 / 0", si_rdy, so_valid);
        else n_pass++;
    endtask

    task automatic test_directed;
        run_job(32'h80, 32'd1, 32'h0, 16'h00FF, 0, 0, 1'b1,
                128'hc8facaa7c280aa28a020aaaf89aae004, 16'h0100, 32'h40, "hit");
        run_job(32'h80, 32'd1, 32'h0, 16'h00FF, 0, 0, 1'b1,
                128'hc8facaa7c280aa28a020aaaf89aae004, 16'h0010, 32'h40, "below_thr");
        run_job(32'h80, 32'd1, 32'h1000, 16'h00FF, 0, 1, 1'b1,
                128'h1234, 16'h00FF, 32'h77, "equal_thr");
    endtask

    task automatic test_back_to_back_stall;
        run_job(32'd300, 32'd3, 32'hA000_0000, 16'h4000, 0, 5, 1'b0, '0, '0, '0, "stall3");
    endtask

    task automatic test_timeout;
        run_job(32'd64, 32'd1, 32'h40, 16'h0001, 2, 2, 1'b0, '0, '0, '0, "timeout");
        run_job(32'd64, 32'd1, 32'h40, 16'h0001, 1, 0, 1'b1, 128'h55, 16'h0200, 32'h99, "done_at_timeout");
    endtask

    task automatic test_zero_len_count;
        bit bad;
        run_job(32'd0, 32'd2, 32'hDEAD_0000, 16'h0000, 0, 1, 1'b0, '0, '0, '0, "zero_len");
        send_word({32'd50, 32'd0, 32'h100, 32'h10}, "zero_cnt_hdr");
        bad = 1'b0;
        repeat (5) begin
            if (so_valid !== 1'b0 || si_rdy !== 1'b1 || ref_req_valid !== 1'b0) bad = 1'b1;
            tick;
        end
        n_total++;
        if (bad) $display("FAIL zero_count: output or fetch seen, or si_rdy low (seen=%b, need 0)", bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        send_word({32'd100, 32'd2, 32'h200, 32'h10}, "rst_hdr");
        send_word(128'hABCD_EF01, "rst_query");
        ref_req_rdy = 1'b1;
        tick;
        ref_req_rdy = 1'b0;
        repeat (3) tick;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({si_rdy, so_valid, ref_req_valid, eng_start, so_data, eng_query, ref_req_addr, ref_req_len} !== '0)
            $display("FAIL reset_mid_run: eng_query=%h addr=%h len=%h flags=%b, need all 0",
                     eng_query, ref_req_addr, ref_req_len, {si_rdy, so_valid, ref_req_valid, eng_start});
        else n_pass++;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
        run_job(32'd20, 32'd1, 32'h300, 16'h0002, 0, 0, 1'b0, '0, '0, '0, "after_reset");
    endtask

    task automatic test_random;
        logic [31:0] len;
        for (int j = 0; j < 5; j++) begin
            len = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            run_job(len, 32'($urandom_range(1, 3)), $urandom(), 16'($urandom()),
                    ($urandom_range(0, 4) == 0) ? 2 : 0, $urandom_range(0, 3),
                    1'b0, '0, '0, '0, "random");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back_stall;
        test_timeout;
        test_zero_len_count;
        test_reset_mid_run;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
